// File: rtl/md_unit_pkg.sv
// ============================================================================
//  Module      : md_unit_pkg
//  Description : Shared op codes, FSM encodings and default latencies for md_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package md_unit_pkg;

   typedef logic [2:0] md_op_t;

   localparam md_op_t MD_MULT  = 3'd0;
   localparam md_op_t MD_MULTU = 3'd1;
   localparam md_op_t MD_DIV   = 3'd2;
   localparam md_op_t MD_DIVU  = 3'd3;
   localparam md_op_t MD_MTHI  = 3'd4;
   localparam md_op_t MD_MTLO  = 3'd5;
   localparam md_op_t MD_MADD  = 3'd6;
   localparam md_op_t MD_MSUB  = 3'd7;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

endpackage

`default_nettype wire

// File: rtl/md_unit_if.sv
// ============================================================================
//  Module      : md_unit_if
//  Description : Request/result bundle between the execute stage and md_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface md_unit_if;
   import md_unit_pkg::*;

   logic        start;
   md_op_t      op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (output start, op, a, b, input busy, hi, lo);
   modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface

`default_nettype wire

// File: rtl/md_unit_calc.sv
// ============================================================================
//  Module      : md_calc
//  Description : Combinational multiply/divide datapath; MADD/MSUB under MDU_MADD_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_calc
   import md_unit_pkg::*;
(
   input  wire md_op_t      op,
   input  wire logic [31:0] a,
   input  wire logic [31:0] b,
   input  wire logic [31:0] hi,
   input  wire logic [31:0] lo,
   output logic      [63:0] result,
   output logic             div0
);

   logic signed [63:0] w_sprod;
   logic        [63:0] w_uprod;
   logic        [31:0] w_udiv, w_uq, w_ur;
   logic        [31:0] w_a_mag, w_b_mag, w_mq, w_mr, w_sq, w_sr;

   assign w_sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
   assign w_uprod = {32'd0, a} * {32'd0, b};

   // Zero divisor is replaced by 1 so the divider never sees x/0; the result is discarded anyway.
   assign w_udiv = (b == 32'd0) ? 32'd1 : b;
   assign w_uq   = a / w_udiv;
   assign w_ur   = a % w_udiv;

   // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000 cleanly.
   assign w_a_mag = a[31] ? (32'd0 - a) : a;
   assign w_b_mag = b[31] ? (32'd0 - b) : w_udiv;
   assign w_mq    = w_a_mag / w_b_mag;
   assign w_mr    = w_a_mag % w_b_mag;
   assign w_sq    = (a[31] ^ b[31]) ? (32'd0 - w_mq) : w_mq;
   assign w_sr    = a[31] ? (32'd0 - w_mr) : w_mr;

`ifndef MDU_MADD_EN
   logic w_unused_acc;
   assign w_unused_acc = ^{hi, lo};
`endif

   always_comb begin
      result = 64'd0;
      div0   = 1'b0;
      case (op)
         MD_MULT:  result = w_sprod;
         MD_MULTU: result = w_uprod;
         MD_DIV: begin
            result = {w_sr, w_sq};
            div0   = (b == 32'd0);
         end
         MD_DIVU: begin
            result = {w_ur, w_uq};
            div0   = (b == 32'd0);
         end
`ifdef MDU_MADD_EN
         MD_MADD:  result = {hi, lo} + w_sprod;
         MD_MSUB:  result = {hi, lo} - w_sprod;
`endif
         default:  result = 64'd0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/md_unit.sv
// ============================================================================
//  Module      : md_unit
//  Description : HI/LO owner with fixed-latency mult/div; MADD/MSUB under MDU_MADD_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_unit
   import md_unit_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  wire logic   clk,
   input  wire logic   reset,
   md_unit_if.slave    bus
);

   localparam int c_max_cycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int c_cnt_w      = $clog2(c_max_cycles + 1);

   logic [0:0]         r_state, w_state_nxt;
   logic [c_cnt_w-1:0] r_cnt, w_cnt_load;
   logic [63:0]        r_pend, w_result;
   logic               r_div0, w_div0;
   logic [31:0]        r_hi, r_lo;
   logic               w_long, w_load, w_commit, w_wr_hi, w_wr_lo, w_busy;

   md_calc u_calc (
      .op     (bus.op),
      .a      (bus.a),
      .b      (bus.b),
      .hi     (r_hi),
      .lo     (r_lo),
      .result (w_result),
      .div0   (w_div0)
   );

   // Multi-cycle op decode and its latency
   always_comb begin
      w_long     = 1'b0;
      w_cnt_load = '0;
      case (bus.op)
         MD_MULT, MD_MULTU: begin
            w_long     = 1'b1;
            w_cnt_load = c_cnt_w'(MULT_CYCLES);
         end
         MD_DIV, MD_DIVU: begin
            w_long     = 1'b1;
            w_cnt_load = c_cnt_w'(DIV_CYCLES);
         end
`ifdef MDU_MADD_EN
         MD_MADD, MD_MSUB: begin
            w_long     = 1'b1;
            w_cnt_load = c_cnt_w'(MULT_CYCLES);
         end
`endif
         default: begin
            w_long     = 1'b0;
            w_cnt_load = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (bus.start && w_long)        w_state_nxt = ST_RUN;
         ST_RUN:  if (r_cnt == c_cnt_w'(1))       w_state_nxt = ST_IDLE;
         default:                                 w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_busy   = (r_state == ST_RUN);
      w_load   = (r_state == ST_IDLE) && bus.start && w_long;
      w_wr_hi  = (r_state == ST_IDLE) && bus.start && (bus.op == MD_MTHI);
      w_wr_lo  = (r_state == ST_IDLE) && bus.start && (bus.op == MD_MTLO);
      w_commit = (r_state == ST_RUN) && (r_cnt == c_cnt_w'(1));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt  <= '0;
         r_pend <= 64'd0;
         r_div0 <= 1'b0;
         r_hi   <= 32'd0;
         r_lo   <= 32'd0;
      end else begin
         if (w_load) begin
            r_cnt  <= w_cnt_load;
            r_pend <= w_result;
            r_div0 <= w_div0;
         end else if (w_busy) begin
            r_cnt  <= r_cnt - c_cnt_w'(1);
         end
         // A zero divisor still costs the full latency but leaves HI/LO untouched.
         if (w_commit && !r_div0) begin
            r_hi <= r_pend[63:32];
            r_lo <= r_pend[31:0];
         end
         if (w_wr_hi) r_hi <= bus.a;
         if (w_wr_lo) r_lo <= bus.a;
      end
   end

   assign bus.busy = w_busy;
   assign bus.hi   = r_hi;
   assign bus.lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_md_unit.sv
// ============================================================================
//  Module      : tb_md_unit
//  Description : Directed self-checking bench for md_unit (default build).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_md_unit;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;
   int   n;

   always #5 clk = ~clk;

   md_unit_if mif ();

   md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (mif)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      mif.start = 1'b1;
      mif.op    = op;
      mif.a     = a;
      mif.b     = b;
      tick();
      mif.start = 1'b0;
   endtask

   // Counts cycles until busy drops; bounded so a stuck busy shows up as a bad count.
   task automatic wait_idle(output int cycles);
      cycles = 0;
      while (mif.busy === 1'b1 && cycles < 50) begin
         cycles++;
         tick();
      end
   endtask

   initial begin
      reset     = 1'b1;
      mif.start = 1'b0;
      mif.op    = 3'd0;
      mif.a     = 32'd0;
      mif.b     = 32'd0;
      #12;
      check("rst_busy", {31'd0, mif.busy}, 32'd0);
      check("rst_hi", mif.hi, 32'd0);
      check("rst_lo", mif.lo, 32'd0);
      tick();
      reset = 1'b0;
      tick();

      // MULT -2 * 3
      issue(3'd0, 32'hFFFF_FFFE, 32'd3);
      check("mult_hold_hi", mif.hi, 32'd0);
      wait_idle(n);
      check("mult_busy_cycles", n, 32'd5);
      check("mult_hi", mif.hi, 32'hFFFF_FFFF);
      check("mult_lo", mif.lo, 32'hFFFF_FFFA);

      // DIVU 100 / 7
      issue(3'd3, 32'd100, 32'd7);
      wait_idle(n);
      check("divu_busy_cycles", n, 32'd10);
      check("divu_lo", mif.lo, 32'd14);
      check("divu_hi", mif.hi, 32'd2);

      // DIV -7 / 2, operands disturbed during RUN
      issue(3'd2, 32'hFFFF_FFF9, 32'd2);
      mif.a = 32'd1000;
      mif.b = 32'd0;
      wait_idle(n);
      check("div_busy_cycles", n, 32'd10);
      check("div_lo", mif.lo, 32'hFFFF_FFFD);
      check("div_hi", mif.hi, 32'hFFFF_FFFF);

      // DIV overflow corner
      issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle(n);
      check("divovf_lo", mif.lo, 32'h8000_0000);
      check("divovf_hi", mif.hi, 32'd0);

      // MTHI / MTLO then divide by zero
      issue(3'd4, 32'h1234_5678, 32'd0);
      check("mthi_hi", mif.hi, 32'h1234_5678);
      check("mthi_busy", {31'd0, mif.busy}, 32'd0);
      issue(3'd5, 32'hCAFE_BABE, 32'd0);
      check("mtlo_lo", mif.lo, 32'hCAFE_BABE);
      issue(3'd2, 32'd55, 32'd0);
      wait_idle(n);
      check("div0_busy_cycles", n, 32'd10);
      check("div0_hi", mif.hi, 32'h1234_5678);
      check("div0_lo", mif.lo, 32'hCAFE_BABE);

      // Op 6 is a no-op in the default build
      issue(3'd6, 32'd3, 32'd4);
      check("nop6_busy", {31'd0, mif.busy}, 32'd0);
      check("nop6_hi", mif.hi, 32'h1234_5678);

      // MULTU max*max with a stray MTLO in cycle 2
      issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      tick();
      issue(3'd5, 32'hDEAD_BEEF, 32'd0);
      check("multu_mtlo_ignored", mif.lo, 32'hCAFE_BABE);
      wait_idle(n);
      check("multu_busy_left", n, 32'd3);
      check("multu_hi", mif.hi, 32'hFFFF_FFFE);
      check("multu_lo", mif.lo, 32'h0000_0001);

      // Reset in the middle of a DIV
      issue(3'd3, 32'd100, 32'd7);
      tick();
      tick();
      tick();
      #2;
      reset = 1'b1;
      #1;
      check("midrst_busy", {31'd0, mif.busy}, 32'd0);
      check("midrst_hi", mif.hi, 32'd0);
      check("midrst_lo", mif.lo, 32'd0);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      check("postrst_busy", {31'd0, mif.busy}, 32'd0);
      check("postrst_hi", mif.hi, 32'd0);
      check("postrst_lo", mif.lo, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
